// File: rtl/sram_arb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl_pkg
//  Description : Shared types and constants for the two-port SRAM arbiter /
//                timing sequencer (state encoding, port id, wait-counter
//                width, legal wait-state range check).
//  Revision    : 1.0  initial release
// ============================================================================
package sram_ctrl_pkg;

   // Wait-state counter width; RD_WAIT-1 / WR_WAIT-1 must fit.
   localparam int CNT_W    = 4;
   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RACK   = 3'd2,
      WSETUP = 3'd3,
      WPULSE = 3'd4,
      WHOLD  = 3'd5
   } state_t;

   // Requester id: 0 = CPU fetch port, 1 = data port.
   typedef logic port_id_t;

   // Used at elaboration to reject wait-state counts the counter cannot hold.
   function automatic bit wait_in_range(input int w);
      return (w >= WAIT_MIN) && (w <= WAIT_MAX);
   endfunction

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_ctrl_if
//  Description : Bus bundle between the two requesters / SRAM pads and the
//                arbiter-sequencer.
//                Requester side : pX_req, pX_we, pX_addr, pX_wdata -> ctrl
//                                 pX_ack, rdata                    <- ctrl
//                SRAM side      : sram_addr, sram_ce_/oe_/we_,
//                                 sram_dq_o, sram_dq_oe            <- ctrl
//                                 sram_dq_i                        -> ctrl
//                master = requesters + pad environment, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_arb_ctrl_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_ack;
   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_ack;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_ce_;
   logic              sram_oe_;
   logic              sram_we_;
   logic [DATA_W-1:0] sram_dq_o;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_i;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p0_ack, p1_ack, rdata,
      input  sram_addr, sram_ce_, sram_oe_, sram_we_, sram_dq_o, sram_dq_oe,
      output sram_dq_i
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p0_ack, p1_ack, rdata,
      output sram_addr, sram_ce_, sram_oe_, sram_we_, sram_dq_o, sram_dq_oe,
      input  sram_dq_i
   );
endinterface : sram_arb_ctrl_if
`default_nettype wire

// File: rtl/sram_arb_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin pick. When both ports
//                request, the one that did not win last time is chosen.
//                The last-grant history is held by the parent.
//  Ports       : req[1:0]   in  request per port
//                last_grant in  port granted most recently
//                enable     in  arbitration allowed this cycle
//                grant      out winning port id
//                valid      out a grant is issued this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_t   last_grant,
   input  logic       enable,
   output port_id_t   grant,
   output logic       valid
);

   always_comb begin
      valid = enable & (|req);
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else begin
         grant = req[1];
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_ctrl
//  Description : Two-port round-robin arbiter and cycle-counted timing
//                sequencer for a 32K x 8 asynchronous SRAM. Every output is
//                a flop so the active-low strobes cannot glitch.
//  Ports       : clk   in  system clock
//                rst_  in  asynchronous active-low reset
//                bus   slave side of sram_arb_ctrl_if (requesters + pads)
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arb_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 8,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 1
)(
   input  logic           clk,
   input  logic           rst_,
   sram_arb_ctrl_if.slave bus
);

   if (!wait_in_range(RD_WAIT)) begin : g_bad_rd_wait
      $error("sram_arb_ctrl: RD_WAIT must be 1..15");
   end
   if (!wait_in_range(WR_WAIT)) begin : g_bad_wr_wait
      $error("sram_arb_ctrl: WR_WAIT must be 1..15");
   end

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   port_id_t          r_gnt, r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_ack0, r_ack1;

   logic              w_ce_n, w_oe_n, w_we_n, w_dq_oe, w_ack0, w_ack1;
   logic              w_capture;
   port_id_t          w_gnt;
   logic              w_gnt_valid;
   logic              w_gnt_we;

   rr_arb2 u_arb (
      .req        ({bus.p1_req, bus.p0_req}),
      .last_grant (r_last),
      .enable     (r_state == IDLE),
      .grant      (w_gnt),
      .valid      (w_gnt_valid)
   );

   assign w_gnt_we = w_gnt ? bus.p1_we : bus.p0_we;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state plus the strobe/ack pattern of that next state; registering
   // the decode of the next state makes each output a clean flop.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               w_state_nxt = w_gnt_we ? WSETUP : RD;
               w_cnt_nxt   = CNT_W'(RD_WAIT - 1);
            end
         end
         RD: begin
            if (r_cnt == '0) begin
               w_state_nxt = RACK;
               w_capture   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         RACK:   w_state_nxt = IDLE;
         WSETUP: begin
            w_state_nxt = WPULSE;
            w_cnt_nxt   = CNT_W'(WR_WAIT - 1);
         end
         WPULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = WHOLD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         WHOLD:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_ce_n  = 1'b1;
      w_oe_n  = 1'b1;
      w_we_n  = 1'b1;
      w_dq_oe = 1'b0;
      case (w_state_nxt)
         RD:      begin w_ce_n = 1'b0; w_oe_n = 1'b0; end
         WSETUP:  begin w_ce_n = 1'b0; w_dq_oe = 1'b1; end
         WPULSE:  begin w_ce_n = 1'b0; w_we_n = 1'b0; w_dq_oe = 1'b1; end
         WHOLD:   begin w_ce_n = 1'b0; w_dq_oe = 1'b1; end
         default: ;
      endcase
      // r_gnt is stable outside IDLE, and IDLE never leads to an ack state.
      w_ack0 = ((w_state_nxt == RACK) || (w_state_nxt == WHOLD)) && (r_gnt == 1'b0);
      w_ack1 = ((w_state_nxt == RACK) || (w_state_nxt == WHOLD)) && (r_gnt == 1'b1);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_dq_oe <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_ce_n  <= w_ce_n;
         r_oe_n  <= w_oe_n;
         r_we_n  <= w_we_n;
         r_dq_oe <= w_dq_oe;
         r_ack0  <= w_ack0;
         r_ack1  <= w_ack1;
         if (w_gnt_valid) begin
            r_gnt   <= w_gnt;
            r_last  <= w_gnt;
            r_addr  <= w_gnt ? bus.p1_addr  : bus.p0_addr;
            r_wdata <= w_gnt ? bus.p1_wdata : bus.p0_wdata;
         end
         if (w_capture) begin
            r_rdata <= bus.sram_dq_i;
         end
      end
   end

   assign bus.p0_ack     = r_ack0;
   assign bus.p1_ack     = r_ack1;
   assign bus.rdata      = r_rdata;
   assign bus.sram_addr  = r_addr;
   assign bus.sram_ce_   = r_ce_n;
   assign bus.sram_oe_   = r_oe_n;
   assign bus.sram_we_   = r_we_n;
   assign bus.sram_dq_o  = r_wdata;
   assign bus.sram_dq_oe = r_dq_oe;

endmodule : sram_arb_ctrl
`default_nettype wire
